// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the registered FSM state encoding, the forward-select encodings
// seen by the execute and decode stages, and the default parameter values.
package hazard_ctrl_pkg;

   localparam int DEF_REG_AW = 3;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_MEM_FREEZE = 2'b10
   } hzState_t;

   // Execute-stage operand source
   typedef enum logic [1:0] {
      EXE_FWD_RF  = 2'b00,
      EXE_FWD_MEM = 2'b01,
      EXE_FWD_WB  = 2'b10
   } exeFwd_t;

   // Decode-stage operand source
   typedef enum logic [1:0] {
      DEC_FWD_RF  = 2'b00,
      DEC_FWD_EXE = 2'b01,
      DEC_FWD_MEM = 2'b10,
      DEC_FWD_WB  = 2'b11
   } decFwd_t;

endpackage

// File: rtl/hazard_ctrl_port_match.sv
// hazard_port_match: match and priority logic for one register read port.
// Ports:
//   decRdReg/decRdVld   decode-stage specifier and use flag for this port
//   exeRdReg/exeRdVld   execute-stage specifier and use flag for this port
//   exeWrReg/memWrReg/wbWrReg, *RegWrite   destination of each older stage
//   exeMemRead/memMemRead                  stage holds a load
//   exeFwdSel   execute operand source (youngest producer wins)
//   decFwdSel   decode operand source (youngest producer wins)
//   loadHz      decode operand depends on a load whose data is not yet ready
module hazard_port_match
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic [REG_AW-1:0] decRdReg,
   input  logic              decRdVld,
   input  logic [REG_AW-1:0] exeRdReg,
   input  logic              exeRdVld,
   input  logic [REG_AW-1:0] exeWrReg,
   input  logic [REG_AW-1:0] memWrReg,
   input  logic [REG_AW-1:0] wbWrReg,
   input  logic              exeRegWrite,
   input  logic              memRegWrite,
   input  logic              wbRegWrite,
   input  logic              exeMemRead,
   input  logic              memMemRead,
   output logic [1:0]        exeFwdSel,
   output logic [1:0]        decFwdSel,
   output logic              loadHz
);

   // The valid flag is the first operand so an undriven specifier on an
   // unused port is masked before it can reach any output.
   logic exeMemMatch, exeWbMatch;
   logic decExeMatch, decMemMatch, decWbMatch;

   assign exeMemMatch = exeRdVld && memRegWrite && (exeRdReg == memWrReg);
   assign exeWbMatch  = exeRdVld && wbRegWrite  && (exeRdReg == wbWrReg);
   assign decExeMatch = decRdVld && exeRegWrite && (decRdReg == exeWrReg);
   assign decMemMatch = decRdVld && memRegWrite && (decRdReg == memWrReg);
   assign decWbMatch  = decRdVld && wbRegWrite  && (decRdReg == wbWrReg);

   always_comb begin
      exeFwdSel = EXE_FWD_RF;
      if (exeMemMatch && !memMemRead)   exeFwdSel = EXE_FWD_MEM;
      else if (exeWbMatch)              exeFwdSel = EXE_FWD_WB;
   end

   always_comb begin
      decFwdSel = DEC_FWD_RF;
      if (decExeMatch && !exeMemRead)      decFwdSel = DEC_FWD_EXE;
      else if (decMemMatch && !memMemRead) decFwdSel = DEC_FWD_MEM;
      else if (decWbMatch)                 decFwdSel = DEC_FWD_WB;
   end

   // A MEM-stage load is shadowed when EXE rewrites the same register with
   // an ALU result; that younger value is forwarded instead.
   assign loadHz = (decExeMatch && exeMemRead) ||
                   (decMemMatch && memMemRead && !(decExeMatch && !exeMemRead));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall and memory-freeze control for a
// five-stage pipeline, with saturating performance counters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dec_rd_reg/dec_rd_vld           decode read specifiers and use flags
//   exe_rd_reg/exe_rd_vld           execute read specifiers and use flags
//   exe/mem/wb_wr_reg, *_reg_write  destination of each stage
//   exe_mem_read/mem_mem_read       stage holds a load
//   dmem_busy                       data memory not ready this cycle
//   cnt_clr                         synchronous clear of both counters
//   exe_fwd_sel/dec_fwd_sel         per-port operand source selects
//   stall_dec/bubble_exe/freeze     pipeline control (combinational)
//   state                           registered FSM state
//   lu_stall_cnt/freeze_cnt         saturating event counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*REG_AW-1:0] dec_rd_reg,
   input  logic [NUM_RD-1:0]        dec_rd_vld,
   input  logic [NUM_RD*REG_AW-1:0] exe_rd_reg,
   input  logic [NUM_RD-1:0]        exe_rd_vld,
   input  logic [REG_AW-1:0]        exe_wr_reg,
   input  logic [REG_AW-1:0]        mem_wr_reg,
   input  logic [REG_AW-1:0]        wb_wr_reg,
   input  logic                     exe_reg_write,
   input  logic                     mem_reg_write,
   input  logic                     wb_reg_write,
   input  logic                     exe_mem_read,
   input  logic                     mem_mem_read,
   input  logic                     dmem_busy,
   input  logic                     cnt_clr,
   output logic [2*NUM_RD-1:0]      exe_fwd_sel,
   output logic [2*NUM_RD-1:0]      dec_fwd_sel,
   output logic                     stall_dec,
   output logic                     bubble_exe,
   output logic                     freeze,
   output logic [1:0]               state,
   output logic [CNT_W-1:0]         lu_stall_cnt,
   output logic [CNT_W-1:0]         freeze_cnt
);

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [NUM_RD-1:0] loadHzVec;
   logic              loadHz;
   hzState_t          stateQ, stateNext;

   for (genvar p = 0; p < NUM_RD; p++) begin : gPort
      hazard_port_match #(.REG_AW(REG_AW)) uMatch (
         .decRdReg    (dec_rd_reg[p*REG_AW +: REG_AW]),
         .decRdVld    (dec_rd_vld[p]),
         .exeRdReg    (exe_rd_reg[p*REG_AW +: REG_AW]),
         .exeRdVld    (exe_rd_vld[p]),
         .exeWrReg    (exe_wr_reg),
         .memWrReg    (mem_wr_reg),
         .wbWrReg     (wb_wr_reg),
         .exeRegWrite (exe_reg_write),
         .memRegWrite (mem_reg_write),
         .wbRegWrite  (wb_reg_write),
         .exeMemRead  (exe_mem_read),
         .memMemRead  (mem_mem_read),
         .exeFwdSel   (exe_fwd_sel[2*p +: 2]),
         .decFwdSel   (dec_fwd_sel[2*p +: 2]),
         .loadHz      (loadHzVec[p])
      );
   end

   assign loadHz = |loadHzVec;

   // A busy data memory freezes everything; a bubble would be lost in the
   // frozen ID/EX register, so it is suppressed until the freeze ends.
   always_comb begin
      stall_dec  = 1'b0;
      bubble_exe = 1'b0;
      freeze     = 1'b0;
      stateNext  = ST_IDLE;
      if (dmem_busy) begin
         stall_dec = 1'b1;
         freeze    = 1'b1;
         stateNext = ST_MEM_FREEZE;
      end else if (loadHz) begin
         stall_dec  = 1'b1;
         bubble_exe = 1'b1;
         stateNext  = ST_LOAD_STALL;
      end
   end

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stateQ <= ST_IDLE;
      else        stateQ <= stateNext;
   end

   assign state = stateQ;

   // ---- counters: clear has priority over a same-cycle increment ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_stall_cnt <= '0;
         freeze_cnt   <= '0;
      end else if (cnt_clr) begin
         lu_stall_cnt <= '0;
         freeze_cnt   <= '0;
      end else begin
         if (bubble_exe) lu_stall_cnt <= satInc(lu_stall_cnt);
         if (dmem_busy)  freeze_cnt   <= satInc(freeze_cnt);
      end
   end

endmodule
